// File: rtl/fetch_redirect_unit_pkg.sv
// FetchUnitTypes: shared types and default sizing for the fetch redirect unit.
//   FetchRedirectState : BOOT / RUN / HALT encoding, also exported on the debug port
//   PC_Path, EpochPath : default-width PC and epoch vectors
//   FETCH_PACKET_BYTES : bytes covered by one fetch packet
//   alignInsn()        : clears the sub-instruction byte offset of a PC
package FetchUnitTypes;

  localparam int          DEF_PC_WIDTH     = 32;
  localparam int          DEF_FETCH_WIDTH  = 2;
  localparam int          DEF_INSN_BYTES   = 4;
  localparam int          DEF_EPOCH_WIDTH  = 3;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_1000;

  localparam int FETCH_PACKET_BYTES = DEF_FETCH_WIDTH * DEF_INSN_BYTES;

  typedef logic [DEF_PC_WIDTH-1:0]    PC_Path;
  typedef logic [DEF_EPOCH_WIDTH-1:0] EpochPath;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } FetchRedirectState;

  function automatic PC_Path alignInsn(PC_Path pc);
    return pc & ~PC_Path'(DEF_INSN_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_redirect_unit_if.sv
// FetchRedirectIf: fetch-PC handshake plus predictor and redirect inputs.
//   master : the redirect unit (drives pcValid, fetchPC, fetchEpoch)
//   slave  : fetch stage / predictor / decode / backend side
interface FetchRedirectIf
  import FetchUnitTypes::*;
#(
  parameter int PC_WIDTH    = DEF_PC_WIDTH,
  parameter int EPOCH_WIDTH = DEF_EPOCH_WIDTH
);

  logic                   pcValid;
  logic                   fetchReady;
  logic [PC_WIDTH-1:0]    fetchPC;
  logic [EPOCH_WIDTH-1:0] fetchEpoch;
  logic                   predTaken;
  logic [PC_WIDTH-1:0]    predTarget;
  logic                   decRedirect;
  logic [PC_WIDTH-1:0]    decRedirectPC;
  logic [EPOCH_WIDTH-1:0] decEpoch;
  logic                   beRedirect;
  logic [PC_WIDTH-1:0]    beRedirectPC;
  logic                   haltReq;

  modport master (
    output pcValid, fetchPC, fetchEpoch,
    input  fetchReady, predTaken, predTarget,
    input  decRedirect, decRedirectPC, decEpoch,
    input  beRedirect, beRedirectPC, haltReq
  );

  modport slave (
    input  pcValid, fetchPC, fetchEpoch,
    output fetchReady, predTaken, predTarget,
    output decRedirect, decRedirectPC, decEpoch,
    output beRedirect, beRedirectPC, haltReq
  );

endinterface

// File: rtl/fetch_redirect_unit.sv
// fetch_redirect_unit: owns the fetch PC, offers it to the fetch stage and
// applies predictor targets, decode redirects and backend recovery.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : FetchRedirectIf.master (handshake, predictor, redirects)
//   state      : FSM state for debug
//
//   state | meaning
//   BOOT  | first cycle out of reset, nothing offered
//   RUN   | fetchPC offered, next-PC mux active
//   HALT  | serializing instruction seen, wait for backend redirect
module fetch_redirect_unit
  import FetchUnitTypes::*;
#(
  parameter int                  PC_WIDTH     = DEF_PC_WIDTH,
  parameter int                  FETCH_WIDTH  = DEF_FETCH_WIDTH,
  parameter int                  INSN_BYTES   = DEF_INSN_BYTES,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(DEF_RESET_VECTOR),
  parameter int                  EPOCH_WIDTH  = DEF_EPOCH_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  FetchRedirectIf.master        bus,
  output logic [1:0]            state
);

  localparam logic [PC_WIDTH-1:0] PKT       = PC_WIDTH'(FETCH_WIDTH * INSN_BYTES);
  localparam logic [PC_WIDTH-1:0] PKT_MASK  = ~(PKT - PC_WIDTH'(1));
  localparam logic [PC_WIDTH-1:0] INSN_MASK = ~PC_WIDTH'(INSN_BYTES - 1);

  FetchRedirectState      stateQ, stateD;
  logic [PC_WIDTH-1:0]    pcQ, pcD;
  logic [EPOCH_WIDTH-1:0] epochQ, epochD;
  logic                   pcValidInt;
  logic                   xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= BOOT;
      pcQ    <= RESET_VECTOR;
      epochQ <= '0;
    end else begin
      stateQ <= stateD;
      pcQ    <= pcD;
      epochQ <= epochD;
    end
  end

  assign xfer = pcValidInt && bus.fetchReady;

  always_comb begin
    stateD = stateQ;
    pcD    = pcQ;
    epochD = epochQ;
    unique case (stateQ)
      BOOT: stateD = RUN;
      RUN: begin
        if (bus.beRedirect) begin
          pcD    = bus.beRedirectPC & INSN_MASK;
          epochD = epochQ + EPOCH_WIDTH'(1);
        end else if (bus.haltReq) begin
          stateD = HALT;
        end else if (bus.decRedirect && (bus.decEpoch == epochQ)) begin
          pcD    = bus.decRedirectPC & INSN_MASK;
          epochD = epochQ + EPOCH_WIDTH'(1);
        end else if (xfer && bus.predTaken) begin
          // stale decode redirects fall through to here
          pcD = bus.predTarget & INSN_MASK;
        end else if (xfer) begin
          pcD = (pcQ & PKT_MASK) + PKT;
        end
      end
      HALT: begin
        if (bus.beRedirect) begin
          stateD = RUN;
          pcD    = bus.beRedirectPC & INSN_MASK;
          epochD = epochQ + EPOCH_WIDTH'(1);
        end
      end
      default: stateD = BOOT;
    endcase
  end

  always_comb begin
    pcValidInt = (stateQ == RUN);
  end

  assign bus.pcValid    = pcValidInt;
  assign bus.fetchPC    = pcQ;
  assign bus.fetchEpoch = epochQ;
  assign state          = stateQ;

endmodule

// File: doc/fetch_redirect_unit.md
Name: fetch_redirect_unit

Overview:
Fetch-side next-PC generator and redirect sink. It owns the architectural fetch PC register and offers it to the I-cache/fetch stage with a valid/ready handshake. It applies branch-predictor targets and accepts redirect requests from the decode-stage branch resolver (flush trigger plus recovered PC) and from backend recovery. It tags every issued PC with an epoch so that decode-stage redirects from stale packets are ignored.

Parameters:
PC_WIDTH, 32, width of PC values
FETCH_WIDTH, 2, instructions per fetch packet
INSN_BYTES, 4, bytes per instruction
RESET_VECTOR, 32'h0000_1000, first fetch PC after reset
EPOCH_WIDTH, 3, width of the redirect epoch tag

Ports:
clk  in  1  clock
rst_n  in  1  reset
pcValid  out  1  fetchPC is valid this cycle
fetchReady  in  1  fetch stage accepts fetchPC this cycle
fetchPC  out  PC_WIDTH  current fetch PC
fetchEpoch  out  EPOCH_WIDTH  epoch tag travelling with fetchPC
predTaken  in  1  predictor: packet at fetchPC contains a taken branch
predTarget  in  PC_WIDTH  predicted target for fetchPC
decRedirect  in  1  decode-stage flush request
decRedirectPC  in  PC_WIDTH  recovered PC from decode
decEpoch  in  EPOCH_WIDTH  epoch of the packet that triggered decRedirect
beRedirect  in  1  backend recovery request
beRedirectPC  in  PC_WIDTH  backend recovery PC
haltReq  in  1  serializing instruction decoded; stop fetch until beRedirect
state  out  2  FSM state, for debug

Behaviour:
- Reset: one clock. Reset is asynchronous and active-low (rst_n). While rst_n=0: fetchPC=RESET_VECTOR, fetchEpoch=0, pcValid=0, state=BOOT.
- FSM, state encoding BOOT=0, RUN=1, HALT=2:
  - BOOT: pcValid=0. Moves unconditionally to RUN on the first clock edge with rst_n=1. Redirects in BOOT are ignored.
  - RUN: pcValid=1.
  - HALT: pcValid=0. Only beRedirect leaves HALT, going to RUN. decRedirect and haltReq are ignored in HALT.
- Transfer: a transfer occurs when pcValid && fetchReady. fetchPC, fetchEpoch and predTaken/predTarget are sampled in that cycle.
- Next-PC priority in RUN, evaluated each cycle and registered, so the effect is visible at the next edge:
  1. beRedirect: fetchPC<=beRedirectPC, epoch<=epoch+1. Overrides haltReq arriving in the same cycle; state stays RUN.
  2. haltReq: state<=HALT. fetchPC and epoch are unchanged.
  3. decRedirect && decEpoch==fetchEpoch: fetchPC<=decRedirectPC, epoch<=epoch+1.
  4. decRedirect && decEpoch!=fetchEpoch: dropped as stale, then fall through to rules 5–6.
  5. Transfer && predTaken: fetchPC<=predTarget.
  6. Transfer && !predTaken: fetchPC<=(fetchPC & ~(PKT-1))+PKT, where PKT=FETCH_WIDTH*INSN_BYTES.
  7. Otherwise: hold fetchPC.
- A redirect applies whether or not fetchReady is high. It replaces the offered PC; a handshake in the same cycle still counts as a transfer downstream, and the new epoch marks that packet stale.
- All loaded PCs (redirect or predicted) have their low log2(INSN_BYTES) bits forced to 0.
- Arithmetic is modulo 2^PC_WIDTH; sequential increment wraps silently. The epoch wraps modulo 2^EPOCH_WIDTH.
- Latency: redirect request to redirected fetchPC is exactly 1 cycle. No bubble is inserted beyond that cycle.
- Asserting rst_n low mid-operation returns immediately to the reset values; any pending intent is lost.

Decomposition:
- Shared package FetchUnitTypes: FetchRedirectState enum (BOOT/RUN/HALT), EpochPath typedef, FETCH_PACKET_BYTES constant. Reuse the existing PC_Path type.
- No sub-module required. The next-PC mux and epoch counter sit inline in one always_comb plus one always_ff.

Test Plan:
- Reset release: rst_n 0→1 → one cycle pcValid=0, state=BOOT; then pcValid=1, fetchPC=0x1000, fetchEpoch=0.
- Sequential: fetchReady=1, predTaken=0 for 3 cycles from 0x1000 → fetchPC 0x1008, 0x1010, 0x1018. fetchReady=0 → PC holds.
- Predicted/stall: at 0x1010 with predTaken=1, predTarget=0x2002 → next fetchPC=0x2000. With fetchReady=0 the PC holds and the predictor is ignored.
- Decode redirect: decRedirect=1, decRedirectPC=0x3000, decEpoch=0 (current 0) → fetchPC=0x3000, epoch=1. Then decRedirect with decEpoch=0 → ignored, sequential advance.
- Priority: beRedirect=0x4000 together with decRedirect=0x3000 and haltReq → fetchPC=0x4000, epoch+1, state RUN.
- Halt: haltReq in RUN → HALT, pcValid=0, decRedirect ignored. beRedirect=0x5000 → RUN, fetchPC=0x5000. Epoch 7 + redirect → 0 (wrap).
